// File: rtl/mem_update_ctrl_if.sv
// Bus bundle for mem_update_ctrl.
//   upd_*     : byte-stream update source (UART/JTAG loader) -> controller
//   cpu_cmd_* : VexRiscv dBus command -> controller
//   mem_*     : controller -> RAM / peripheral decode
// slave  : the controller's view.
// master : the view of the block(s) surrounding the controller.
interface mem_update_ctrl_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [7:0]  upd_data;
    logic        upd_last;

    logic        cpu_cmd_valid;
    logic        cpu_cmd_ready;
    logic        cpu_cmd_wr;
    logic [31:0] cpu_cmd_addr;
    logic [31:0] cpu_cmd_data;
    logic [1:0]  cpu_cmd_size;

    logic        mem_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_size;

    modport slave (
        input  upd_valid, upd_data, upd_last,
        input  cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_addr, cpu_cmd_data, cpu_cmd_size,
        output upd_ready, cpu_cmd_ready,
        output mem_valid, mem_wr, mem_addr, mem_data, mem_size
    );

    modport master (
        output upd_valid, upd_data, upd_last,
        output cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_addr, cpu_cmd_data, cpu_cmd_size,
        input  upd_ready, cpu_cmd_ready,
        input  mem_valid, mem_wr, mem_addr, mem_data, mem_size
    );
endinterface

// File: rtl/mem_update_ctrl.sv
// Program-memory data-port owner. Shares the byte-enabled RAM port between the
// CPU dBus and a byte-stream image loader. An update stalls the CPU for one
// drain cycle, holds it in reset while bytes are written from address 0, keeps
// reset asserted for RESET_HOLD more cycles, then releases it.
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   upd_start   : one-cycle request to begin an update (ignored unless idle)
//   bus         : upd_*/cpu_cmd_*/mem_* bundle (slave view)
//   cpu_reset   : OR'd into the CPU reset by the top level
//   busy        : high whenever not idle
//   upd_done    : one-cycle pulse in the final reset-hold cycle
module mem_update_ctrl #(
    parameter int MEM_ADDR_BITS = 11,
    parameter int RESET_HOLD    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd_start,
    mem_update_ctrl_if.slave   bus,
    output logic               cpu_reset,
    output logic               busy,
    output logic               upd_done
);
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [HW-1:0]            hold_q, hold_d;
    logic                     cpu_reset_q, cpu_reset_d;
    logic                     busy_q, busy_d;
    logic                     upd_done_q, upd_done_d;
    logic                     upd_ready_q, upd_ready_d;
    logic                     upd_hs;

    // upd_ready_q is high exactly while in LOAD, so this is the load handshake.
    assign upd_hs = bus.upd_valid & upd_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (upd_start) state_d = DRAIN;
            end
            DRAIN: state_d = LOAD;
            LOAD: begin
                if (upd_hs) begin
                    cnt_d = cnt_q + 1'b1;   // wraps: overlong images overwrite from 0
                    if (bus.upd_last) begin
                        state_d = HOLD;
                        hold_d  = HW'(RESET_HOLD - 1);
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        cpu_reset_d = (state_d == LOAD) || (state_d == HOLD);
        busy_d      = (state_d != IDLE);
        upd_ready_d = (state_d == LOAD);
        upd_done_d  = (state_d == HOLD) && (hold_d == '0);
    end

    // RAM port mux: CPU passthrough when idle, loader bytes in LOAD, quiet otherwise.
    always_comb begin
        bus.cpu_cmd_ready = (state_q == IDLE);
        bus.upd_ready     = upd_ready_q;
        bus.mem_valid     = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_data      = '0;
        bus.mem_size      = 2'd0;
        case (state_q)
            IDLE: begin
                bus.mem_valid = bus.cpu_cmd_valid;
                bus.mem_wr    = bus.cpu_cmd_wr;
                bus.mem_addr  = bus.cpu_cmd_addr;
                bus.mem_data  = bus.cpu_cmd_data;
                bus.mem_size  = bus.cpu_cmd_size;
            end
            LOAD: begin
                // Byte replicated on all lanes; size 0 selects the lane from addr[1:0].
                // Upper address bits are zero so loads never hit peripheral space.
                bus.mem_valid = upd_hs;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = {{(32-MEM_ADDR_BITS){1'b0}}, cnt_q};
                bus.mem_data  = {4{bus.upd_data}};
                bus.mem_size  = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            upd_done_q  <= 1'b0;
            upd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            upd_done_q  <= upd_done_d;
            upd_ready_q <= upd_ready_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign upd_done  = upd_done_q;
endmodule

// File: tb/tb_mem_update_ctrl.sv
module tb_mem_update_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic upd_start;
    logic cpu_reset, busy, upd_done;

    always #5 clk = ~clk;

    mem_update_ctrl_if bus();

    mem_update_ctrl #(.MEM_ADDR_BITS(11), .RESET_HOLD(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .upd_start (upd_start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .upd_done  (upd_done)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] img[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM command must match the next expected one, in order.
    always @(negedge clk) begin
        exp_t got, e;
        if (bus.mem_valid === 1'b1) begin
            got.wr   = bus.mem_wr;
            got.addr = bus.mem_addr;
            got.data = bus.mem_data;
            got.size = bus.mem_size;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_unexpected: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mem_cmd: got wr=%0b addr=%h data=%h size=%0d expected wr=%0b addr=%h data=%h size=%0d",
                             got.wr, got.addr, got.data, got.size, e.wr, e.addr, e.data, e.size);
                end
            end
        end
    end

    task automatic clear_inputs();
        upd_start         = 1'b0;
        bus.upd_valid     = 1'b0;
        bus.upd_data      = 8'h00;
        bus.upd_last      = 1'b0;
        bus.cpu_cmd_valid = 1'b0;
        bus.cpu_cmd_wr    = 1'b0;
        bus.cpu_cmd_addr  = 32'h0;
        bus.cpu_cmd_data  = 32'h0;
        bus.cpu_cmd_size  = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s);
        bus.cpu_cmd_valid = 1'b1;
        bus.cpu_cmd_wr    = wr;
        bus.cpu_cmd_addr  = a;
        bus.cpu_cmd_data  = d;
        bus.cpu_cmd_size  = s;
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
        exp_t e;
        e.wr = wr; e.addr = a; e.data = d; e.size = s;
        exp_q.push_back(e);
    endtask

    // Runs one update of img. A stalled CPU write is held valid through DRAIN/LOAD;
    // it must never reach the RAM port (the monitor has no expectation for it).
    task automatic run_update(input bit gaps, input bit with_read, input bit finish,
                              output int rst_cyc);
        int n;
        int hold, dones, done_at, k;
        n = img.size();
        step(); clear_inputs();
        upd_start = 1'b1;
        if (with_read) begin
            drive_cpu(1'b0, 32'h0000_0020, 32'h0, 2'd2);
            push(1'b0, 32'h0000_0020, 32'h0, 2'd2);
        end
        @(negedge clk);
        chk("start_cmd_ready", bus.cpu_cmd_ready, 1);
        chk("start_busy", busy, 0);

        step(); clear_inputs();
        drive_cpu(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2'd2);
        @(negedge clk);
        chk("drain_mem_valid", bus.mem_valid, 0);
        chk("drain_cmd_ready", bus.cpu_cmd_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_cpu_reset", cpu_reset, 0);
        chk("drain_upd_ready", bus.upd_ready, 0);

        rst_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                step();
                bus.upd_valid = 1'b0;
                @(negedge clk);
                rst_cyc += int'(cpu_reset);
                chk("gap_cmd_ready", bus.cpu_cmd_ready, 0);
            end
            step();
            bus.upd_valid = 1'b1;
            bus.upd_data  = img[i];
            bus.upd_last  = finish && (i == n - 1);
            push(1'b1, 32'(i % 2048), {4{img[i]}}, 2'd0);
            @(negedge clk);
            rst_cyc += int'(cpu_reset);
            chk("load_upd_ready", bus.upd_ready, 1);
        end
        step(); clear_inputs();

        if (finish) begin
            hold = 0; dones = 0; done_at = -1; k = 0;
            @(negedge clk);
            chk("cnt_after_last", 32'(dut.cnt_q), 32'(n % 2048));
            while (busy && k < 40) begin
                hold++;
                rst_cyc += int'(cpu_reset);
                chk("hold_upd_ready", bus.upd_ready, 0);
                if (upd_done) begin dones++; done_at = hold; end
                step();
                @(negedge clk);
                k++;
            end
            chk("hold_cycles", hold, 8);
            chk("done_pulses", dones, 1);
            chk("done_in_last_hold", done_at, 8);
            chk("release_cpu_reset", cpu_reset, 0);
            chk("release_cmd_ready", bus.cpu_cmd_ready, 1);
            chk("release_upd_done", upd_done, 0);
        end
    endtask

    initial begin
        int rc;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_reset", cpu_reset, 0);
        chk("rst_upd_done", upd_done, 0);
        chk("rst_upd_ready", bus.upd_ready, 0);
        step(); reset = 1'b0;

        // Idle passthrough, including peripheral space.
        step();
        drive_cpu(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2);
        push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2);
        @(negedge clk);
        chk("idle_cmd_ready", bus.cpu_cmd_ready, 1);
        step();
        drive_cpu(1'b0, 32'h8000_0004, 32'h1234_5678, 2'd1);
        push(1'b0, 32'h8000_0004, 32'h1234_5678, 2'd1);
        @(negedge clk);

        // 4-byte image: reset held 4 load + 8 hold cycles.
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_update(1'b0, 1'b0, 1'b1, rc);
        chk("upd4_reset_cycles", rc, 12);

        // upd_start together with a CPU read.
        img = '{8'hA1, 8'hB2, 8'hC3};
        run_update(1'b0, 1'b1, 1'b1, rc);
        chk("upd3_reset_cycles", rc, 11);

        // Gapped stream: 6 bytes over 12 load cycles.
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_update(1'b1, 1'b0, 1'b1, rc);
        chk("gap_reset_cycles", rc, 20);

        // 2049-byte stream: last byte wraps to address 0.
        img.delete();
        for (int i = 0; i < 2049; i++) img.push_back(8'(i) ^ 8'h5A);
        run_update(1'b0, 1'b0, 1'b1, rc);
        chk("wrap_reset_cycles", rc, 2049 + 8);

        // Reset mid-LOAD after 5 bytes.
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_update(1'b0, 1'b0, 1'b0, rc);
        chk("abort_reset_cycles", rc, 5);
        reset = 1'b1;
        @(negedge clk);
        step(); reset = 1'b0;
        drive_cpu(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 2'd2);
        push(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 2'd2);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_cpu_reset", cpu_reset, 0);
        chk("abort_cmd_ready", bus.cpu_cmd_ready, 1);
        chk("abort_upd_ready", bus.upd_ready, 0);

        step(); clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
